// File: rtl/ctrl_cmd_host_if.sv
// Signal bundle between the command host and its request source / UART byte pair.
// The master modport is the host block itself; slave is the surrounding environment.
interface ctrl_cmd_host_if;
   logic       cmd_start;
   logic [7:0] cmd_code;
   logic [7:0] cmd_param;
   logic [7:0] tx_in;
   logic       tx_write;
   logic       tx_over;
   logic [7:0] rx_out;
   logic       rx_over;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       timeout;
   logic [7:0] status_byte;
   logic [7:0] level_byte;

   modport master (
      input  cmd_start, cmd_code, cmd_param, tx_over, rx_out, rx_over,
      output tx_in, tx_write, busy, done, ack_ok, timeout, status_byte, level_byte
   );

   modport slave (
      output cmd_start, cmd_code, cmd_param, tx_over, rx_out, rx_over,
      input  tx_in, tx_write, busy, done, ack_ok, timeout, status_byte, level_byte
   );
endinterface

// File: rtl/ctrl_cmd_host.sv
// Host-side command initiator: sends a command byte (plus optional parameter byte)
// over uart_tx, then gathers the receiver's response bytes from uart_rx.
module ctrl_cmd_host #(
   parameter int unsigned CMD_GAP      = 8,
   parameter logic [23:0] RESP_TIMEOUT = 24'd2000000
) (
   input logic             clk,
   input logic             rst_n,
   ctrl_cmd_host_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, SEND_CMD, WAIT_CMD, GAP, SEND_PARAM, WAIT_PARAM, WAIT_RESP, FINISH
   } state_t;

   state_t      state, state_next;
   logic [7:0]  code, param, tx_byte, ack_byte, status_q, level_q;
   logic        tx_over_q, rx_over_q, tx_pos, rx_pos;
   logic [1:0]  resp_need, resp_cnt;
   logic        need_param, idle_like, accept, capture, take_byte, expire, timed_out;
   logic        gap_end;
   logic [15:0] gap_cnt;
   logic [23:0] wait_cnt;

   assign tx_pos    = ~tx_over_q & bus.tx_over;
   assign rx_pos    = ~rx_over_q & bus.rx_over;
   assign idle_like = (state == IDLE) || (state == FINISH);
   assign accept    = bus.cmd_start && idle_like;
   assign gap_end   = (32'(gap_cnt) + 32'd1) >= CMD_GAP;

   always_comb begin
      resp_need  = 2'd0;
      need_param = 1'b0;
      case (code)
         8'd2, 8'd3: resp_need = 2'd1;
         8'd4:       resp_need = 2'd3;
         8'd5:       need_param = 1'b1;
         8'd6: begin
            resp_need  = 2'd1;
            need_param = 1'b1;
         end
         default:    resp_need = 2'd0;
      endcase
   end

   // Capture opens once the last byte of the command has been strobed out.
   assign capture   = (state == WAIT_RESP) || (state == WAIT_PARAM) ||
                      ((state == WAIT_CMD) && !need_param);
   assign take_byte = capture && rx_pos && (resp_cnt < resp_need);
   assign expire    = (state == WAIT_RESP) && !take_byte && (resp_cnt < resp_need) &&
                      (wait_cnt >= RESP_TIMEOUT - 24'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (accept) state_next = SEND_CMD;
         SEND_CMD:   state_next = WAIT_CMD;
         WAIT_CMD: begin
            if (tx_pos) begin
               if (need_param)          state_next = GAP;
               else if (resp_need != 0) state_next = WAIT_RESP;
               else                     state_next = FINISH;
            end
         end
         GAP:        if (gap_end) state_next = SEND_PARAM;
         SEND_PARAM: state_next = WAIT_PARAM;
         WAIT_PARAM: begin
            if (tx_pos) state_next = (resp_need != 0) ? WAIT_RESP : FINISH;
         end
         WAIT_RESP:  if ((resp_cnt == resp_need) || expire) state_next = FINISH;
         FINISH:     state_next = accept ? SEND_CMD : IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_over_q <= 1'b0;
         rx_over_q <= 1'b0;
         code      <= 8'd0;
         param     <= 8'd0;
         tx_byte   <= 8'd0;
         ack_byte  <= 8'd0;
         status_q  <= 8'd0;
         level_q   <= 8'd127;
         resp_cnt  <= 2'd0;
         gap_cnt   <= 16'd0;
         wait_cnt  <= 24'd0;
         timed_out <= 1'b0;
      end else begin
         tx_over_q <= bus.tx_over;
         rx_over_q <= bus.rx_over;
         if (accept) begin
            code      <= bus.cmd_code;
            param     <= bus.cmd_param;
            tx_byte   <= bus.cmd_code;
            ack_byte  <= 8'd0;
            resp_cnt  <= 2'd0;
            wait_cnt  <= 24'd0;
            timed_out <= 1'b0;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
         if ((state == GAP) && gap_end) tx_byte <= param;
         if (take_byte) begin
            resp_cnt <= resp_cnt + 2'd1;
            wait_cnt <= 24'd0;
            if ((code == 8'd4) && (resp_cnt == 2'd0)) status_q <= bus.rx_out;
            if ((code == 8'd4) && (resp_cnt == 2'd1)) level_q  <= bus.rx_out;
            if (resp_cnt == resp_need - 2'd1)         ack_byte <= bus.rx_out;
         end else if ((state == WAIT_RESP) && (wait_cnt != 24'hFF_FFFF)) begin
            wait_cnt <= wait_cnt + 24'd1;
         end
         if (expire) timed_out <= 1'b1;
      end
   end

   // Result flags are only meaningful in the single FINISH cycle that is the done pulse.
   assign bus.tx_in       = tx_byte;
   assign bus.tx_write    = (state == SEND_CMD) || (state == SEND_PARAM);
   assign bus.busy        = !idle_like;
   assign bus.done        = (state == FINISH);
   assign bus.ack_ok      = (state == FINISH) &&
                            ((resp_need == 2'd0) || (!timed_out && (ack_byte == 8'd1)));
   assign bus.timeout     = (state == FINISH) && timed_out;
   assign bus.status_byte = status_q;
   assign bus.level_byte  = level_q;

endmodule

// File: tb/tb_ctrl_cmd_host.sv
// Self-checking bench for ctrl_cmd_host: directed vector table, hand sequences for
// reset/stray-byte corners, then random commands against a protocol-level model.
module tb_ctrl_cmd_host;

   localparam int unsigned GAP_CYCLES = 8;
   localparam logic [23:0] TO_CYCLES  = 24'd100;

   typedef struct {
      string      name;
      logic [7:0] code;
      logic [7:0] param;
      int         nbytes;
      logic [7:0] b0, b1, b2;
      bit         sameCycle;
      bit         poke;
      int         ntx;
      bit         expAck;
      bit         expTo;
      logic [7:0] expStatus;
      logic [7:0] expLevel;
   } vector_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;

   ctrl_cmd_host_if tbBus ();

   ctrl_cmd_host #(.CMD_GAP(GAP_CYCLES), .RESP_TIMEOUT(TO_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (tbBus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int         testsRun = 0;
   int         testsFailed = 0;
   logic [7:0] txLog[$];
   int         txCyc[$];
   int         doneCount = 0;
   bit         lastAck, lastTo, busyAtDone, busyAfter;
   int         doneCyc, firstRise, lastRise, startDone;
   logic [7:0] modelStatus, modelLevel;
   vector_t    vecs[$];

   // Observe strobes and completion pulses half a cycle away from the active edge.
   always @(negedge clk) begin
      if (tbBus.tx_write) begin
         txLog.push_back(tbBus.tx_in);
         txCyc.push_back(cyc);
      end
      if (tbBus.done) begin
         doneCount++;
         lastAck    = tbBus.ack_ok;
         lastTo     = tbBus.timeout;
         busyAtDone = tbBus.busy;
         doneCyc    = cyc;
      end
   end

   function automatic int respCount(input logic [7:0] code);
      case (code)
         8'd2, 8'd3, 8'd6: return 1;
         8'd4:             return 3;
         default:          return 0;
      endcase
   endfunction

   function automatic int txCount(input logic [7:0] code);
      return ((code == 8'd5) || (code == 8'd6)) ? 2 : 1;
   endfunction

   function automatic logic [31:0] getTx(input int i);
      return (txLog.size() > i) ? 32'(txLog[i]) : 32'hFFFF_FFFF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pulseRx(input logic [7:0] b);
      tbBus.rx_out  = b;
      tbBus.rx_over = 1'b1;
      @(posedge clk) #1;
      tbBus.rx_over = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] code, input logic [7:0] param, input int nbytes,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input bit sameCycle, input bit poke, input int ntx);
      logic [7:0] b[3];
      int         first;
      b[0] = b0; b[1] = b1; b[2] = b2;
      first = 0;
      txLog.delete();
      txCyc.delete();
      startDone = doneCount;
      @(posedge clk) #1;
      tbBus.cmd_start = 1'b1;
      tbBus.cmd_code  = code;
      tbBus.cmd_param = param;
      @(posedge clk) #1;
      tbBus.cmd_start = 1'b0;
      tbBus.cmd_param = 8'hEE;
      @(negedge clk) busyAfter = tbBus.busy;
      for (int t = 0; t < ntx; t++) begin
         for (int k = 0; (k < 200) && (txLog.size() <= t); k++) @(posedge clk);
         if (txLog.size() <= t) begin
            checkOutput("txWriteSeen", 32'(txLog.size()), 32'(t + 1));
            return;
         end
         #1;
         if (poke && (t == 0)) begin
            tbBus.cmd_start = 1'b1;
            tbBus.cmd_code  = 8'd3;
            @(posedge clk) #1;
            tbBus.cmd_start = 1'b0;
         end
         repeat (3) @(posedge clk);
         #1;
         tbBus.tx_over = 1'b1;
         if (t == 0) firstRise = cyc;
         lastRise = cyc;
         if ((t == ntx - 1) && sameCycle && (nbytes > 0)) begin
            tbBus.rx_out  = b[0];
            tbBus.rx_over = 1'b1;
            first = 1;
         end
         @(posedge clk) #1;
         tbBus.tx_over = 1'b0;
         tbBus.rx_over = 1'b0;
      end
      for (int i = first; i < nbytes; i++) begin
         repeat (2) @(posedge clk);
         #1;
         pulseRx(b[i]);
      end
      for (int k = 0; (k < int'(TO_CYCLES) + 200) && (doneCount == startDone); k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic verifyCommand(input string name, input logic [7:0] code, input logic [7:0] param,
                                input int ntx, input bit expAck, input bit expTo,
                                input logic [7:0] st, input logic [7:0] lv, input bit checkLat);
      checkOutput({name, ".doneCount"}, 32'(doneCount - startDone), 32'd1);
      checkOutput({name, ".txCount"}, 32'(txLog.size()), 32'(ntx));
      checkOutput({name, ".tx0"}, getTx(0), 32'(code));
      if (ntx == 2) begin
         checkOutput({name, ".tx1"}, getTx(1), 32'(param));
         if (txCyc.size() > 1)
            checkOutput({name, ".gapOk"}, 32'((txCyc[1] - firstRise - 1) >= int'(GAP_CYCLES)), 32'd1);
      end
      checkOutput({name, ".busyAccept"}, 32'(busyAfter), 32'd1);
      checkOutput({name, ".busyAtDone"}, 32'(busyAtDone), 32'd0);
      checkOutput({name, ".ackOk"}, 32'(lastAck), 32'(expAck));
      checkOutput({name, ".timeout"}, 32'(lastTo), 32'(expTo));
      checkOutput({name, ".statusByte"}, 32'(tbBus.status_byte), 32'(st));
      checkOutput({name, ".levelByte"}, 32'(tbBus.level_byte), 32'(lv));
      if (checkLat)
         checkOutput({name, ".timeoutLatency"}, 32'(doneCyc - lastRise), 32'(int'(TO_CYCLES) + 1));
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, ".txIn"}, 32'(tbBus.tx_in), 32'd0);
      checkOutput({name, ".txWrite"}, 32'(tbBus.tx_write), 32'd0);
      checkOutput({name, ".busy"}, 32'(tbBus.busy), 32'd0);
      checkOutput({name, ".done"}, 32'(tbBus.done), 32'd0);
      checkOutput({name, ".ackOk"}, 32'(tbBus.ack_ok), 32'd0);
      checkOutput({name, ".timeout"}, 32'(tbBus.timeout), 32'd0);
      checkOutput({name, ".statusByte"}, 32'(tbBus.status_byte), 32'd0);
      checkOutput({name, ".levelByte"}, 32'(tbBus.level_byte), 32'd127);
   endtask

   initial begin
      tbBus.cmd_start = 1'b0;
      tbBus.cmd_code  = 8'd0;
      tbBus.cmd_param = 8'd0;
      tbBus.tx_over   = 1'b0;
      tbBus.rx_out    = 8'd0;
      tbBus.rx_over   = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("powerOnReset");
      rst_n = 1'b1;

      //                 name          code   param  n  b0     b1     b2    same poke ntx ack to  status level
      vecs.push_back(vector_t'{"on",        8'd2, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h7F});
      vecs.push_back(vector_t'{"status",    8'd4, 8'h00, 3, 8'h03, 8'h55, 8'h01, 0, 0, 1, 1, 0, 8'h03, 8'h55});
      vecs.push_back(vector_t'{"statusNak", 8'd4, 8'h00, 3, 8'h0A, 8'h20, 8'h02, 0, 0, 1, 0, 0, 8'h0A, 8'h20});
      vecs.push_back(vector_t'{"level",     8'd6, 8'h40, 1, 8'h01, 8'h00, 8'h00, 0, 0, 2, 1, 0, 8'h0A, 8'h20});
      vecs.push_back(vector_t'{"silence",   8'd5, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 0, 2, 1, 0, 8'h0A, 8'h20});
      vecs.push_back(vector_t'{"offTmo",    8'd3, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 1, 8'h0A, 8'h20});
      vecs.push_back(vector_t'{"statusTmo", 8'd4, 8'h00, 2, 8'h07, 8'h66, 8'h00, 0, 0, 1, 0, 1, 8'h07, 8'h66});
      vecs.push_back(vector_t'{"reset",     8'd1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 0, 8'h07, 8'h66});
      vecs.push_back(vector_t'{"raw",       8'h9A, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 0, 8'h07, 8'h66});
      vecs.push_back(vector_t'{"onNak",     8'd2, 8'h00, 1, 8'h02, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h07, 8'h66});
      vecs.push_back(vector_t'{"busyPoke",  8'd4, 8'h00, 3, 8'h21, 8'h42, 8'h01, 0, 1, 1, 1, 0, 8'h21, 8'h42});
      vecs.push_back(vector_t'{"onSame",    8'd2, 8'h00, 1, 8'h01, 8'h00, 8'h00, 1, 0, 1, 1, 0, 8'h21, 8'h42});
      vecs.push_back(vector_t'{"levelSame", 8'd6, 8'h7F, 1, 8'h01, 8'h00, 8'h00, 1, 0, 2, 1, 0, 8'h21, 8'h42});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].code, vecs[i].param, vecs[i].nbytes, vecs[i].b0, vecs[i].b1,
                       vecs[i].b2, vecs[i].sameCycle, vecs[i].poke, vecs[i].ntx);
         verifyCommand(vecs[i].name, vecs[i].code, vecs[i].param, vecs[i].ntx, vecs[i].expAck,
                       vecs[i].expTo, vecs[i].expStatus, vecs[i].expLevel,
                       vecs[i].expTo && (vecs[i].nbytes == 0));
      end

      // A byte arriving while idle must be dropped without any visible effect.
      startDone = doneCount;
      txLog.delete();
      @(posedge clk) #1;
      pulseRx(8'h01);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("strayRx.doneCount", 32'(doneCount - startDone), 32'd0);
      checkOutput("strayRx.txCount", 32'(txLog.size()), 32'd0);
      checkOutput("strayRx.busy", 32'(tbBus.busy), 32'd0);
      checkOutput("strayRx.statusByte", 32'(tbBus.status_byte), 32'h21);
      checkOutput("strayRx.levelByte", 32'(tbBus.level_byte), 32'h42);

      // Reset asserted while a STATUS command is still collecting responses.
      txLog.delete();
      startDone = doneCount;
      @(posedge clk) #1;
      tbBus.cmd_start = 1'b1;
      tbBus.cmd_code  = 8'd4;
      @(posedge clk) #1;
      tbBus.cmd_start = 1'b0;
      for (int k = 0; (k < 200) && (txLog.size() == 0); k++) @(posedge clk);
      checkOutput("midReset.txWriteSeen", 32'(txLog.size()), 32'd1);
      #1;
      repeat (3) @(posedge clk);
      #1;
      tbBus.tx_over = 1'b1;
      @(posedge clk) #1;
      tbBus.tx_over = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pulseRx(8'h11);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midReset.statusBefore", 32'(tbBus.status_byte), 32'h11);
      checkOutput("midReset.busyBefore", 32'(tbBus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midReset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midReset.noDone", 32'(doneCount - startDone), 32'd0);
      applyStimulus(8'd2, 8'h00, 1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1);
      verifyCommand("afterReset", 8'd2, 8'h00, 1, 1'b1, 1'b0, 8'h00, 8'h7F, 1'b0);

      // Random commands checked against the protocol rules, with sticky status/level.
      modelStatus = 8'h00;
      modelLevel  = 8'h7F;
      for (int it = 0; it < 16; it++) begin
         logic [7:0] code, param, bb[3];
         int         n, nb, ntx;
         bit         same, expAck, expTo;
         code  = 8'($urandom_range(0, 6));
         if (code == 8'd0) code = 8'($urandom_range(7, 255));
         param = 8'($urandom);
         n     = respCount(code);
         ntx   = txCount(code);
         nb    = ((n > 0) && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(0, n - 1)) : n;
         for (int j = 0; j < 3; j++) bb[j] = 8'($urandom);
         if ((n > 0) && ($urandom_range(0, 1) == 1)) bb[n - 1] = 8'd1;
         same   = 1'($urandom_range(0, 1));
         expTo  = (nb < n);
         expAck = (n == 0) ? 1'b1 : (!expTo && (bb[n - 1] == 8'd1));
         if ((code == 8'd4) && (nb >= 1)) modelStatus = bb[0];
         if ((code == 8'd4) && (nb >= 2)) modelLevel  = bb[1];
         applyStimulus(code, param, nb, bb[0], bb[1], bb[2], same, 1'b0, ntx);
         verifyCommand($sformatf("rand%0d", it), code, param, ntx, expAck, expTo,
                       modelStatus, modelLevel, expTo && (nb == 0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
